// File: rtl/sisc_ctrl_mc_if.sv
// sisc_ctrl_mc_if -- bundle between the SISC multi-cycle controller and its
// datapath.
//
// Signals:
//   opcode    IR opcode field (held stable by the IR for a whole instruction)
//   mm, stat  branch condition mask and ALU status flags (STAT_W bits)
//   dm_ready  data memory access complete
//   run       resume request while halted
//   rf_we, wb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load, mm_sel,
//   dm_we, rb_sel  one-bit datapath controls
//   alu_op    ALU function (ALU_OP_W bits)
//   halted    core halted
//   mem_err   sticky memory timeout
//   instr_cnt retired-instruction count (CNT_W bits)
//   state     controller state, for observation only
//
// Memory handshake: while the controller is in MEM for a load/store it
// presents mm_sel (and dm_we for stores) every cycle; the access completes on
// the first rising edge at which dm_ready=1. dm_ready is ignored in every
// other state. There is no back-pressure on the control outputs.
//
// Modports: slave is the controller, master is the datapath/memory side.
interface sisc_ctrl_mc_if #(
  parameter int STAT_W   = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
);
  logic [3:0]          opcode;
  logic [STAT_W-1:0]   mm;
  logic [STAT_W-1:0]   stat;
  logic                dm_ready;
  logic                run;
  logic                rf_we;
  logic                wb_sel;
  logic                pc_sel;
  logic                pc_write;
  logic                pc_rst;
  logic                br_sel;
  logic                ir_load;
  logic                mm_sel;
  logic                dm_we;
  logic                rb_sel;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                mem_err;
  logic [CNT_W-1:0]    instr_cnt;
  logic [2:0]          state;

  modport master (
    output opcode, mm, stat, dm_ready, run,
    input  rf_we, wb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load,
           mm_sel, dm_we, rb_sel, alu_op, halted, mem_err, instr_cnt, state
  );

  modport slave (
    input  opcode, mm, stat, dm_ready, run,
    output rf_we, wb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load,
           mm_sel, dm_we, rb_sel, alu_op, halted, mem_err, instr_cnt, state
  );
endinterface

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc -- multi-cycle control unit for the SISC core.
//
// Sequence per instruction: FETCH, DECODE, EXECUTE, MEM, WRITEBACK. HLT
// leaves DECODE for HALT and waits for run. Loads/stores wait in MEM for
// dm_ready; if MEM_TMO cycles pass without it the controller parks in ERROR
// until reset.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sisc_ctrl_mc_if.slave (inputs from IR/ALU/memory, datapath controls,
//        status and the state observation field)
//
// Outputs are combinational from the registered state and the inputs.
module sisc_ctrl_mc #(
  parameter int STAT_W   = 4,
  parameter int ALU_OP_W = 4,
  parameter int MEM_TMO  = 15,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  sisc_ctrl_mc_if.slave  bus
);

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_REG_OP = 4'd1;
  localparam logic [3:0] OP_REG_IM = 4'd2;
  localparam logic [3:0] OP_SWAP   = 4'd3;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_BNR    = 4'd7;
  localparam logic [3:0] OP_JPA    = 4'd8;
  localparam logic [3:0] OP_JPR    = 4'd9;
  localparam logic [3:0] OP_LOD    = 4'd10;
  localparam logic [3:0] OP_STA    = 4'd11;
  localparam logic [3:0] OP_STX    = 4'd12;
  localparam logic [3:0] OP_LDA    = 4'd13;
  localparam logic [3:0] OP_LDX    = 4'd14;
  localparam logic [3:0] OP_HLT    = 4'd15;

  // The wait counter increments on this cycle's miss and reaches MEM_TMO,
  // so a miss seen with the counter one short of MEM_TMO is the timeout.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic             is_mem;
  logic             cond;

  assign is_mem = (bus.opcode == OP_STA) || (bus.opcode == OP_STX) ||
                  (bus.opcode == OP_LDA) || (bus.opcode == OP_LDX);
  assign cond   = |(bus.mm & bus.stat);

  assign bus.state     = state;
  assign bus.instr_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nx;
    end
  end

  // Held at zero outside MEM, so it is already clear on MEM entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != S_MEM) begin
      wait_cnt <= '0;
    end else if (!bus.dm_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_WRITEBACK) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:     state_nx = S_FETCH;
      S_FETCH:     state_nx = S_DECODE;
      S_DECODE:    state_nx = (bus.opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_nx = S_MEM;
      S_MEM: begin
        // dm_ready wins over a timeout landing on the same cycle.
        if (!is_mem || bus.dm_ready) begin
          state_nx = S_WRITEBACK;
        end else if (wait_cnt == TMO_LAST) begin
          state_nx = S_ERROR;
        end
      end
      S_WRITEBACK: state_nx = S_FETCH;
      S_HALT:      state_nx = bus.run ? S_FETCH : S_HALT;
      S_ERROR:     state_nx = S_ERROR;
      default:     state_nx = S_RESET;
    endcase
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.mm_sel   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.rb_sel   = 1'b0;
    bus.alu_op   = '0;
    bus.halted   = 1'b0;
    bus.mem_err  = 1'b0;
    case (state)
      S_RESET: bus.pc_rst = 1'b1;
      S_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_DECODE: begin
        // br_sel picks the absolute target, pc_sel the branch path.
        case (bus.opcode)
          OP_BRA: begin bus.pc_sel = 1'b1; bus.br_sel = 1'b1; bus.pc_write = cond;  end
          OP_BRR: begin bus.pc_sel = 1'b1;                    bus.pc_write = cond;  end
          OP_BNE: begin bus.pc_sel = 1'b1; bus.br_sel = 1'b1; bus.pc_write = ~cond; end
          OP_BNR: begin bus.pc_sel = 1'b1;                    bus.pc_write = ~cond; end
          OP_JPA: begin bus.pc_sel = 1'b1; bus.br_sel = 1'b1; bus.pc_write = 1'b1;  end
          OP_JPR: begin bus.pc_sel = 1'b1;                    bus.pc_write = 1'b1;  end
          default: ;
        endcase
      end
      S_EXECUTE: begin
        case (bus.opcode)
          OP_REG_OP:                      bus.alu_op = ALU_OP_W'(1);
          OP_REG_IM:                      bus.alu_op = ALU_OP_W'(3);
          OP_STA, OP_STX, OP_LDA, OP_LDX: bus.alu_op = ALU_OP_W'(2);
          default:                        bus.alu_op = '0;
        endcase
      end
      S_MEM: begin
        case (bus.opcode)
          OP_REG_IM: bus.alu_op = ALU_OP_W'(2);
          OP_STA:    begin bus.mm_sel = 1'b1; bus.dm_we = 1'b1; end
          OP_STX:    begin bus.mm_sel = 1'b1; bus.dm_we = 1'b1; bus.rb_sel = 1'b1; end
          OP_LDA:    begin bus.mm_sel = 1'b1; bus.wb_sel = 1'b1; end
          OP_LDX:    begin bus.mm_sel = 1'b1; bus.wb_sel = 1'b1; bus.rb_sel = 1'b1; end
          default: ;
        endcase
      end
      S_WRITEBACK: begin
        case (bus.opcode)
          OP_REG_OP, OP_REG_IM: bus.rf_we = 1'b1;
          OP_LDA:               begin bus.rf_we = 1'b1; bus.wb_sel = 1'b1; end
          OP_LDX:               begin bus.rf_we = 1'b1; bus.wb_sel = 1'b1; bus.rb_sel = 1'b1; end
          default: ;
        endcase
      end
      S_HALT:  bus.halted  = 1'b1;
      S_ERROR: bus.mem_err = 1'b1;
      default: ;
    endcase
  end

  // Opcodes that need no special handling in any state.
  logic unused_ops;
  assign unused_ops = ^{OP_NOOP, OP_SWAP, OP_LOD};

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb_sisc_ctrl_mc -- bench for sisc_ctrl_mc (CNT_W=4, MEM_TMO=15).
// Each cycle's expected output word {state, instr_cnt, controls, alu_op,
// halted, mem_err} is queued with its stimulus and compared one cycle at a
// time, sampled 1 ns after the falling edge.
module tb_sisc_ctrl_mc;

  localparam int W = 23;

  localparam logic [3:0] OP_NOOP = 4'd0,  OP_REG_OP = 4'd1, OP_REG_IM = 4'd2,
                         OP_SWAP = 4'd3,  OP_BRA = 4'd4,    OP_BRR = 4'd5,
                         OP_BNE = 4'd6,   OP_BNR = 4'd7,    OP_JPA = 4'd8,
                         OP_JPR = 4'd9,   OP_LOD = 4'd10,   OP_STA = 4'd11,
                         OP_STX = 4'd12,  OP_LDA = 4'd13,   OP_LDX = 4'd14,
                         OP_HLT = 4'd15;

  localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXECUTE = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6, ST_ERROR = 3'd7;

  // control bit order: rf_we wb_sel pc_sel pc_write pc_rst br_sel ir_load mm_sel dm_we rb_sel
  localparam logic [9:0] M_RF = 10'h200, M_WB = 10'h100, M_PCS = 10'h080,
                         M_PCW = 10'h040, M_PCR = 10'h020, M_BRS = 10'h010,
                         M_IR = 10'h008, M_MM = 10'h004, M_DW = 10'h002,
                         M_RB = 10'h001;

  typedef struct {
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       rdy;
    logic       run;
  } stim_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_cnt;

  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];

  sisc_ctrl_mc_if #(.STAT_W(4), .ALU_OP_W(4), .CNT_W(4)) bus ();

  sisc_ctrl_mc #(
    .STAT_W(4), .ALU_OP_W(4), .MEM_TMO(15), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(input logic [2:0] st, input int cnt,
                                      input logic [9:0] c, input logic [3:0] alu,
                                      input logic h, input logic e);
    logic [3:0] cv;
    cv = cnt[3:0];
    return {st, cv, c, alu, h, e};
  endfunction

  function automatic logic [W-1:0] sample();
    return {bus.state, bus.instr_cnt, bus.rf_we, bus.wb_sel, bus.pc_sel,
            bus.pc_write, bus.pc_rst, bus.br_sel, bus.ir_load, bus.mm_sel,
            bus.dm_we, bus.rb_sel, bus.alu_op, bus.halted, bus.mem_err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                      input logic rdy, input logic rn, input logic [W-1:0] e);
    stim_t st;
    st.op = op; st.mm = m; st.stat = s; st.rdy = rdy; st.run = rn;
    stim_q.push_back(st);
    exp_q.push_back(e);
  endtask

  task automatic step(output logic [W-1:0] o);
    stim_t s;
    s = stim_q.pop_front();
    @(negedge clk);
    bus.opcode   = s.op;
    bus.mm       = s.mm;
    bus.stat     = s.stat;
    bus.dm_ready = s.rdy;
    bus.run      = s.run;
    #1;
    o = sample();
  endtask

  // Queue one non-HLT instruction; loads/stores see dm_ready low for
  // wait_lo MEM cycles and high on the next.
  task automatic queue_instr(input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] s, input int wait_lo);
    logic       cnd;
    logic       memop;
    logic [9:0] d;
    logic [9:0] mc;
    logic [9:0] wc;
    logic [3:0] ea;
    logic [3:0] ma;
    cnd   = |(m & s);
    memop = (op == OP_STA) || (op == OP_STX) || (op == OP_LDA) || (op == OP_LDX);
    push(op, m, s, 1'b0, 1'b0, pk(ST_FETCH, exp_cnt, M_IR | M_PCW, 4'd0, 1'b0, 1'b0));
    d = 10'h000;
    case (op)
      OP_BRA: d = M_PCS | M_BRS | (cnd ? M_PCW : 10'h000);
      OP_BRR: d = M_PCS | (cnd ? M_PCW : 10'h000);
      OP_BNE: d = M_PCS | M_BRS | (cnd ? 10'h000 : M_PCW);
      OP_BNR: d = M_PCS | (cnd ? 10'h000 : M_PCW);
      OP_JPA: d = M_PCS | M_BRS | M_PCW;
      OP_JPR: d = M_PCS | M_PCW;
      default: d = 10'h000;
    endcase
    push(op, m, s, 1'b0, 1'b0, pk(ST_DECODE, exp_cnt, d, 4'd0, 1'b0, 1'b0));
    ea = 4'd0;
    if (op == OP_REG_OP) ea = 4'd1;
    if (op == OP_REG_IM) ea = 4'd3;
    if (memop)           ea = 4'd2;
    push(op, m, s, 1'b0, 1'b0, pk(ST_EXECUTE, exp_cnt, 10'h000, ea, 1'b0, 1'b0));
    mc = 10'h000; ma = 4'd0; wc = 10'h000;
    case (op)
      OP_REG_OP: wc = M_RF;
      OP_REG_IM: begin ma = 4'd2; wc = M_RF; end
      OP_STA:    mc = M_MM | M_DW;
      OP_STX:    mc = M_MM | M_DW | M_RB;
      OP_LDA:    begin mc = M_MM | M_WB;        wc = M_RF | M_WB; end
      OP_LDX:    begin mc = M_MM | M_WB | M_RB; wc = M_RF | M_WB | M_RB; end
      default: ;
    endcase
    if (memop) begin
      for (int k = 0; k <= wait_lo; k++)
        push(op, m, s, (k == wait_lo), 1'b0, pk(ST_MEM, exp_cnt, mc, ma, 1'b0, 1'b0));
    end else begin
      push(op, m, s, 1'($urandom_range(0, 1)), 1'b0, pk(ST_MEM, exp_cnt, mc, ma, 1'b0, 1'b0));
    end
    push(op, m, s, 1'b0, 1'b0, pk(ST_WB, exp_cnt, wc, 4'd0, 1'b0, 1'b0));
    exp_cnt = exp_cnt + 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] o;
    logic [W-1:0] e;
    @(negedge clk);
    #1;
    o = sample();
    e = pk(ST_RESET, 0, M_PCR, 4'd0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_state: got %h want %h", o, e); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reg_op();
    logic [W-1:0] o;
    logic [W-1:0] e;
    queue_instr(OP_REG_OP, 4'h0, 4'h0, 0);
    queue_instr(OP_NOOP, 4'h0, 4'h0, 0);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reg_op: got %h want %h", o, e); end
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] o;
    logic [W-1:0] e;
    queue_instr(OP_BNE, 4'b0010, 4'b0010, 0);
    queue_instr(OP_BNE, 4'b0010, 4'b0000, 0);
    queue_instr(OP_BRA, 4'b1000, 4'b1001, 0);
    queue_instr(OP_BRR, 4'b0100, 4'b0011, 0);
    queue_instr(OP_BNR, 4'b0001, 4'b0001, 0);
    queue_instr(OP_JPA, 4'b0000, 4'b1111, 0);
    queue_instr(OP_JPR, 4'b1111, 4'b0000, 0);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL branch: got %h want %h", o, e); end
    end
  endtask

  task automatic test_ldx_wait();
    logic [W-1:0] o;
    logic [W-1:0] e;
    queue_instr(OP_LDX, 4'h0, 4'h0, 3);
    queue_instr(OP_LDA, 4'h0, 4'h0, 1);
    queue_instr(OP_STX, 4'h0, 4'h0, 0);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ldx_wait: got %h want %h", o, e); end
    end
  endtask

  task automatic test_ready_at_timeout();
    logic [W-1:0] o;
    logic [W-1:0] e;
    queue_instr(OP_STA, 4'h0, 4'h0, 14);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ready_at_timeout: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] o;
    logic [W-1:0] e;
    for (int i = 0; i < 8; i++)
      queue_instr(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 5));
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back: got %h want %h", o, e); end
    end
  endtask

  task automatic test_hlt();
    logic [W-1:0] o;
    logic [W-1:0] e;
    // run during FETCH/DECODE must not matter
    push(OP_HLT, 4'h0, 4'h0, 1'b0, 1'b1, pk(ST_FETCH, exp_cnt, M_IR | M_PCW, 4'd0, 1'b0, 1'b0));
    push(OP_HLT, 4'h0, 4'h0, 1'b0, 1'b1, pk(ST_DECODE, exp_cnt, 10'h000, 4'd0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      push(OP_HLT, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_HALT, exp_cnt, 10'h000, 4'd0, 1'b1, 1'b0));
    push(OP_HLT, 4'h0, 4'h0, 1'b0, 1'b1, pk(ST_HALT, exp_cnt, 10'h000, 4'd0, 1'b1, 1'b0));
    queue_instr(OP_REG_IM, 4'h0, 4'h0, 0);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL hlt: got %h want %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] o;
    logic [W-1:0] e;
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_FETCH, exp_cnt, M_IR | M_PCW, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_DECODE, exp_cnt, 10'h000, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_EXECUTE, exp_cnt, 10'h000, 4'd2, 1'b0, 1'b0));
    for (int k = 0; k < 15; k++)
      push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_MEM, exp_cnt, M_MM | M_DW, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_ERROR, exp_cnt, 10'h000, 4'd0, 1'b0, 1'b1));
    push(OP_STA, 4'h0, 4'h0, 1'b1, 1'b1, pk(ST_ERROR, exp_cnt, 10'h000, 4'd0, 1'b0, 1'b1));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_ERROR, exp_cnt, 10'h000, 4'd0, 1'b0, 1'b1));
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout: got %h want %h", o, e); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    o = sample();
    e = pk(ST_RESET, 0, M_PCR, 4'd0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL error_reset: got %h want %h", o, e); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_wrap_async_reset();
    logic [W-1:0] o;
    logic [W-1:0] e;
    for (int i = 0; i < 16; i++)
      queue_instr(OP_REG_IM, 4'h0, 4'h0, 0);
    // after 16 retirements the 4-bit count is back to 0 in this FETCH
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_FETCH, 0, M_IR | M_PCW, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_DECODE, 0, 10'h000, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_EXECUTE, 0, 10'h000, 4'd2, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_MEM, 0, M_MM | M_DW, 4'd0, 1'b0, 1'b0));
    push(OP_STA, 4'h0, 4'h0, 1'b0, 1'b0, pk(ST_MEM, 0, M_MM | M_DW, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap: got %h want %h", o, e); end
    end
    // reset lands between edges while still in MEM
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    o = sample();
    e = pk(ST_RESET, 0, M_PCR, 4'd0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %h want %h", o, e); end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    queue_instr(OP_REG_OP, 4'h0, 4'h0, 0);
    while (exp_q.size() > 0) begin
      step(o); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL after_reset: got %h want %h", o, e); end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    exp_cnt      = 0;
    rst          = 1'b1;
    bus.opcode   = 4'h0;
    bus.mm       = 4'h0;
    bus.stat     = 4'h0;
    bus.dm_ready = 1'b0;
    bus.run      = 1'b0;
    test_reset();
    test_reg_op();
    test_branch();
    test_ldx_wait();
    test_ready_at_timeout();
    test_back_to_back();
    test_hlt();
    test_timeout();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl_mc.md
SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

Interface
REQ-001 The block SHALL provide parameter STAT_W, default 4, the width of the mm and stat condition fields.
REQ-002 The block SHALL provide parameter ALU_OP_W, default 4 (minimum 4), the width of alu_op.
REQ-003 The block SHALL provide parameter MEM_TMO, default 15 (range 1..255), the maximum number of MEM wait cycles before a memory timeout.
REQ-004 The block SHALL provide parameter CNT_W, default 16, the width of the retired-instruction counter.
REQ-005 The block SHALL have these ports; it has one clock, and reset is asynchronous and active-high:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  4  IR opcode field.
- mm  in  STAT_W  branch condition mask.
- stat  in  STAT_W  ALU status flags.
- dm_ready  in  1  data memory access complete.
- run  in  1  resume from halt.
- rf_we, wb_sel, pc_sel, pc_write, pc_rst, br_sel, ir_load, mm_sel, dm_we, rb_sel  out  1 each  datapath controls.
- alu_op  out  ALU_OP_W  ALU function.
- halted  out  1  core halted.
- mem_err  out  1  memory timeout, sticky.
- instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-006 The opcodes SHALL be: NOOP 0, REG_OP 1, REG_IM 2, SWAP 3, BRA 4, BRR 5, BNE 6, BNR 7, JPA 8, JPR 9, LOD 10, STA 11, STX 12, LDA 13, LDX 14, HLT 15.
REQ-007 The state machine SHALL have the states RESET, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT and ERROR, with registered state and combinational outputs.
REQ-008 The state transitions SHALL be:
- RESET->FETCH.
- FETCH->DECODE.
- DECODE->HALT if opcode=HLT, otherwise EXECUTE.
- EXECUTE->MEM.
- MEM->WRITEBACK per REQ-013.
- WRITEBACK->FETCH.
- HALT->FETCH when run=1.
- ERROR holds until reset.
REQ-009 Every control output SHALL default to 0 in every state unless a requirement below sets it.
REQ-010 In RESET, pc_rst SHALL be 1.
REQ-011 In FETCH, ir_load and pc_write SHALL be 1.
REQ-012 In DECODE, the branch controls SHALL be, with cond = |(mm & stat):
- BRA and JPA: pc_sel=1, br_sel=1.
- BRR and JPR: pc_sel=1, br_sel=0.
- BNE: as BRA, with pc_write = ~cond.
- BNR: as BRR, with pc_write = ~cond.
- BRA and BRR: pc_write = cond.
- JPA and JPR: pc_write = 1.
REQ-013 For a memory opcode (STA, STX, LDA, LDX), MEM SHALL hold until dm_ready=1, then go to WRITEBACK on the next edge; for every other opcode, MEM SHALL last exactly 1 cycle.
REQ-014 A wait counter SHALL clear on MEM entry and increment each MEM cycle with dm_ready=0; when it reaches MEM_TMO with dm_ready still 0, the next state SHALL be ERROR.
REQ-015 In EXECUTE, alu_op SHALL be zero-extended to ALU_OP_W as follows:
- REG_OP: 1.
- REG_IM: 3.
- STA, STX, LDA, LDX: 2.
- all other opcodes: 0.
REQ-016 In MEM, the controls SHALL be:
- REG_IM: alu_op=2.
- STA and STX: mm_sel=1 and dm_we=1 on every MEM cycle; STX also sets rb_sel=1.
- LDA and LDX: mm_sel=1 and wb_sel=1; LDX also sets rb_sel=1.
REQ-017 In WRITEBACK, the controls SHALL be:
- REG_OP and REG_IM: rf_we=1, wb_sel=0.
- LDA and LDX: rf_we=1, wb_sel=1; LDX also sets rb_sel=1.
- dm_we=0 for every opcode.
REQ-018 In HALT, halted SHALL be 1 and all other controls 0; run=1 during HALT SHALL produce FETCH next cycle, while run outside HALT SHALL be ignored.
REQ-019 In ERROR, mem_err=1 and all other controls 0.
REQ-020 instr_cnt SHALL increment by 1 modulo 2^CNT_W on each WRITEBACK cycle; HLT SHALL NOT count.
REQ-021 A dm_ready=1 arriving on the same cycle the counter reaches MEM_TMO SHALL take priority, giving WRITEBACK and no error.

Reset
REQ-022 rst=1 SHALL immediately force state RESET, clear the wait counter, instr_cnt and mem_err, and drive pc_rst=1 with all other outputs 0, including when reset arrives mid-MEM or in ERROR.
REQ-023 After rst falls, the first rising edge SHALL enter FETCH.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then REG_OP: FETCH, DECODE, EXECUTE (alu_op=1), MEM (alu_op=0), WRITEBACK (rf_we=1); instr_cnt=1 after 5 cycles.
- BNE with mm=4'b0010 and stat=4'b0010 in DECODE: pc_write=0. With stat=4'b0000: pc_write=1, pc_sel=1, br_sel=1.
- LDX with dm_ready low for 3 cycles: MEM lasts 4 cycles with mm_sel=1, wb_sel=1, rb_sel=1; WRITEBACK has rf_we=1.
- STA with dm_ready held 0 and MEM_TMO=15: ERROR entered after 15 MEM cycles with mem_err=1 and dm_we=0; rst clears it.
- HLT: halted=1 with instr_cnt unchanged; 2 cycles with run=0 stay in HALT; run=1 gives FETCH next cycle.
- CNT_W=4: 16 REG_IM instructions wrap instr_cnt to 0; rst asserted mid-MEM gives pc_rst=1 asynchronously.
